// File: rtl/lane_gather_if.sv
// Valid/ready bundle for the lane gather block: a narrow beat stream in and a
// packed multi-lane word with its lane mask out.
interface lane_gather_if #(
    parameter int LANES = 4,
    parameter int WIDTH = 8
);
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             in_data;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic [LANES-1:0][WIDTH-1:0]  out_data;
    logic [LANES-1:0]             out_mask;

    // Producer/consumer side: drives beats in, accepts words out.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_mask
    );

    // Gather block side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_mask
    );
endinterface

// File: rtl/lane_gather.sv
// Lane gather: packs a stream of WIDTH-bit beats into one LANES-lane word.
// Lane 0 holds the first beat of a word. A word closes when the last lane is
// written or when in_last arrives early; unwritten lanes read as zero and the
// mask marks which lanes carry data. While a word is held, the next beat is
// only accepted in the same cycle the held word retires, which keeps a
// throughput of one beat per cycle without a bubble.
module lane_gather #(
    parameter int LANES = 4,
    parameter int WIDTH = 8
) (
    input  logic         clock,
    input  logic         reset,
    lane_gather_if.slave bus
);
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [IDX_W-1:0]             idx_q;
    logic [IDX_W-1:0]             idx_d;
    logic [LANES-1:0][WIDTH-1:0]  word_q;
    logic [LANES-1:0][WIDTH-1:0]  word_d;
    logic [LANES-1:0]             mask_q;
    logic [LANES-1:0]             mask_d;

    logic                         in_ready_s;
    logic                         in_fire_s;
    logic                         out_fire_s;
    logic [IDX_W-1:0]             lane_s;
    logic                         closing_s;

    // Handshake qualification: a held word blocks input unless it retires now;
    // reset forces the input closed so no beat is claimed during reset.
    always_comb begin
        in_ready_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (state_q == COLLECT) || bus.out_ready;
        end
        in_fire_s  = bus.in_valid && in_ready_s;
        out_fire_s = (state_q == HOLD) && bus.out_ready;
    end

    // Next-state for buffer, mask, lane index and word state. A retiring word
    // is zeroed first so a coincident beat lands in lane 0 of a clean word.
    always_comb begin
        word_d    = word_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        state_d   = state_q;
        lane_s    = idx_q;
        closing_s = 1'b0;

        if (out_fire_s) begin
            word_d  = '0;
            mask_d  = {LANES{1'b0}};
            idx_d   = {IDX_W{1'b0}};
            lane_s  = {IDX_W{1'b0}};
            state_d = COLLECT;
        end else begin
            lane_s  = idx_q;
        end

        if (in_fire_s) begin
            word_d[lane_s] = bus.in_data;
            mask_d[lane_s] = 1'b1;
            closing_s      = (lane_s == LAST_IDX) || bus.in_last;
            if (closing_s) begin
                idx_d   = {IDX_W{1'b0}};
                state_d = HOLD;
            end else begin
                idx_d   = lane_s + IDX_W'(1);
            end
        end else begin
            closing_s = 1'b0;
        end
    end

    // Gather FSM and datapath registers; reset discards any partial word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= COLLECT;
            idx_q   <= {IDX_W{1'b0}};
            word_q  <= '0;
            mask_q  <= {LANES{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_data  = word_q;
    assign bus.out_mask  = mask_q;
endmodule

// File: tb/tb_lane_gather.sv
// Directed bench for lane_gather with LANES=4, WIDTH=8.
module tb_lane_gather;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    lane_gather_if #(.LANES(4), .WIDTH(8)) bus ();

    lane_gather #(.LANES(4), .WIDTH(8)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic v, input logic [31:0] d, input logic [3:0] m);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, {31'd0, v});
        chk({tag, "_data"},  bus.out_data, d);
        chk({tag, "_mask"},  {28'd0, bus.out_mask}, {28'd0, m});
    endtask

    // Directed sequence.
    initial begin
        logic [31:0] held;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        #1;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk_word("rst", 1'b0, 32'h0000_0000, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // 1: full word 11,22,33,44
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        chk("t1_not_yet", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b1, 8'h44, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk_word("t1", 1'b1, 32'h4433_2211, 4'hF);
        tick();
        chk_word("t1_retire", 1'b0, 32'h0000_0000, 4'h0);

        // 2: early last on second beat
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk_word("t2", 1'b1, 32'h0000_2211, 4'h3);
        tick();
        chk("t2_retire", {31'd0, bus.out_valid}, 32'd0);

        // 3: backpressure for 3 cycles with a pending beat
        bus.out_ready = 1'b0;
        drive(1'b1, 8'h01, 1'b0); tick();
        drive(1'b1, 8'h02, 1'b0); tick();
        drive(1'b1, 8'h03, 1'b0); tick();
        drive(1'b1, 8'h04, 1'b0); tick();
        drive(1'b1, 8'h55, 1'b0);
        #1;
        chk_word("t3_held", 1'b1, 32'h0403_0201, 4'hF);
        chk("t3_in_ready0", {31'd0, bus.in_ready}, 32'd0);
        held = bus.out_data;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_word("t3_stall", 1'b1, 32'h0403_0201, 4'hF);
            chk("t3_stall_rdy", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("t3_rdy_same_cycle", {31'd0, bus.in_ready}, 32'd1);
        tick();
        chk_word("t3_retired", 1'b0, 32'h0000_0055, 4'h1);
        drive(1'b1, 8'h66, 1'b0); tick();
        drive(1'b1, 8'h77, 1'b0); tick();
        drive(1'b1, 8'h88, 1'b0); tick();
        chk_word("t3_next", 1'b1, 32'h8877_6655, 4'hF);

        // 5: word retires while AA (with last) arrives
        drive(1'b1, 8'hAA, 1'b1);
        #1;
        chk("t5_in_ready", {31'd0, bus.in_ready}, 32'd1);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        chk_word("t5", 1'b1, 32'h0000_00AA, 4'h1);
        tick();
        chk_word("t5_retire", 1'b0, 32'h0000_0000, 4'h0);

        // 4: twelve back-to-back beats
        for (int k = 1; k <= 12; k++) begin
            drive(1'b1, 8'(k), 1'b0);
            #1;
            chk("t4_in_ready", {31'd0, bus.in_ready}, 32'd1);
            tick();
            if ((k % 4) == 0) begin
                chk_word("t4_word", 1'b1, {8'(k), 8'(k - 1), 8'(k - 2), 8'(k - 3)}, 4'hF);
            end else begin
                chk("t4_gap", {31'd0, bus.out_valid}, 32'd0);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        chk("t4_end", {31'd0, bus.out_valid}, 32'd0);

        // 6: reset mid-word, then full word closed by last on the 4th beat
        drive(1'b1, 8'h77, 1'b0); tick();
        drive(1'b1, 8'h78, 1'b0); tick();
        rst = 1'b1;
        drive(1'b1, 8'h99, 1'b0);
        #1;
        chk("t6_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        chk_word("t6_after_rst", 1'b0, 32'h0000_0000, 4'h0);
        drive(1'b1, 8'h01, 1'b0); tick();
        drive(1'b1, 8'h02, 1'b0); tick();
        drive(1'b1, 8'h03, 1'b0); tick();
        chk("t6_no_partial", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b1, 8'h04, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk_word("t6", 1'b1, 32'h0403_0201, 4'hF);
        tick();
        chk("t6_retire", {31'd0, bus.out_valid}, 32'd0);
        chk("t3_held_snapshot", held, 32'h0403_0201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
